// File: rtl/spart_pkg.sv
// Shared types for the SPART bus controller: register map, status bit positions and FSM states.
// No logic here, so no latency and no backpressure.
package spart_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'b00,
        ADDR_STATUS = 2'b01,
        ADDR_DB_LO  = 2'b10,
        ADDR_DB_HI  = 2'b11
    } addr_e;

    localparam int STAT_RX_NE  = 0;
    localparam int STAT_TX_NF  = 1;
    localparam int STAT_OVR    = 2;
    localparam int STAT_CNT_LO = 4;
    localparam int STAT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACT  = 2'b01,
        GAP  = 2'b10
    } fsm_state_e;

    // The status register only has a 4-bit occupancy field.
    function automatic logic [3:0] sat_cnt(input logic [6:0] cnt);
        return (cnt > 7'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinational head: a push is visible at the head one cycle later.
// A push while full is dropped unless a pop happens in the same cycle; a pop while empty only counts alongside a push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A concurrent pop frees the slot a full-FIFO push lands in, so both proceed.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & (~empty_o | push_i);

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spart_bus_ctrl.sv
// SPART processor-bus controller with buffered TX/RX FIFOs. Reads are combinational; TX sends at most one character every 3 cycles.
// Writes to a full TX FIFO are dropped, and received characters arriving while the RX FIFO is full set the sticky overrun flag.
module spart_bus_ctrl
    import spart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iocs,
    input  logic              iorw,
    input  logic [1:0]        ioaddr,
    inout  wire  [DATA_W-1:0] databus,
    input  logic              rda,
    input  logic [DATA_W-1:0] recieve_read_line,
    output logic              recieve_read_en,
    input  logic              tbr,
    output logic [DATA_W-1:0] write_line,
    output logic              transmit_write_en,
    output logic [DATA_W-1:0] baud_write_data,
    output logic              baud_write_en,
    output logic              baud_write_location
);

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    addr_e             addr;
    logic              rd;
    logic              wr;
    logic              data_rd;
    logic              stat_rd;
    logic              data_wr;
    logic              div_wr;
    logic [DATA_W-1:0] rd_dat;

    logic              tx_push;
    logic              tx_pop;
    logic [DATA_W-1:0] tx_head;
    logic              tx_full;
    logic              tx_empty;
    logic [TX_CW-1:0]  tx_cnt;

    logic              rx_push;
    logic              rx_pop;
    logic [DATA_W-1:0] rx_head;
    logic              rx_full;
    logic              rx_empty;
    logic [RX_CW-1:0]  rx_cnt;

    fsm_state_e        tx_state_q;
    fsm_state_e        tx_state_d;
    fsm_state_e        rx_state_q;
    fsm_state_e        rx_state_d;

    logic              ovr_set;
    logic              overrun_q;
    logic              overrun_d;
    logic              baud_en_q;
    logic [DATA_W-1:0] baud_dat_q;
    logic              baud_loc_q;
    logic              unused_tx_cnt;

    assign addr    = addr_e'(ioaddr);
    assign rd      = iocs & iorw;
    assign wr      = iocs & ~iorw;
    assign data_rd = rd & (addr == ADDR_DATA);
    assign stat_rd = rd & (addr == ADDR_STATUS);
    assign data_wr = wr & (addr == ADDR_DATA);
    assign div_wr  = wr & ioaddr[1];

    assign tx_push = data_wr;
    assign tx_pop  = transmit_write_en;
    assign rx_push = recieve_read_en;
    assign rx_pop  = data_rd & ~rx_empty;

    assign unused_tx_cnt = ^tx_cnt;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (tx_push),
        .push_dat_i (databus),
        .pop_i      (tx_pop),
        .head_o     (tx_head),
        .full_o     (tx_full),
        .empty_o    (tx_empty),
        .count_o    (tx_cnt)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (rx_push),
        .push_dat_i (recieve_read_line),
        .pop_i      (rx_pop),
        .head_o     (rx_head),
        .full_o     (rx_full),
        .empty_o    (rx_empty),
        .count_o    (rx_cnt)
    );

    always_comb begin
        rd_dat = '0;
        case (addr)
            ADDR_DATA: begin
                if (!rx_empty) begin
                    rd_dat = rx_head;
                end
            end
            ADDR_STATUS: begin
                rd_dat[STAT_RX_NE] = ~rx_empty;
                rd_dat[STAT_TX_NF] = ~tx_full;
                rd_dat[STAT_OVR]   = overrun_q;
                rd_dat[STAT_CNT_LO +: STAT_CNT_W] = sat_cnt(7'(rx_cnt));
            end
            default: rd_dat = '0;
        endcase
    end

    assign databus = rd ? rd_dat : {DATA_W{1'bz}};

    always_comb begin
        tx_state_d        = tx_state_q;
        transmit_write_en = 1'b0;
        write_line        = '0;
        case (tx_state_q)
            IDLE: if (tbr && !tx_empty) tx_state_d = ACT;
            ACT: begin
                transmit_write_en = 1'b1;
                write_line        = tx_head;
                tx_state_d        = GAP;
            end
            GAP:     tx_state_d = IDLE;
            default: tx_state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_state_d      = rx_state_q;
        recieve_read_en = 1'b0;
        case (rx_state_q)
            IDLE: if (rda) rx_state_d = ACT;
            ACT: begin
                recieve_read_en = 1'b1;
                rx_state_d      = GAP;
            end
            GAP:     rx_state_d = IDLE;
            default: rx_state_d = IDLE;
        endcase
    end

    // A processor pop in the same cycle makes room, so that take is not an overrun.
    assign ovr_set   = recieve_read_en & rx_full & ~rx_pop;
    assign overrun_d = ovr_set | (overrun_q & ~stat_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= IDLE;
            rx_state_q <= IDLE;
            overrun_q  <= 1'b0;
            baud_en_q  <= 1'b0;
            baud_dat_q <= '0;
            baud_loc_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            overrun_q  <= overrun_d;
            baud_en_q  <= div_wr;
            if (div_wr) begin
                baud_dat_q <= databus;
                baud_loc_q <= ioaddr[0];
            end
        end
    end

    assign baud_write_en       = baud_en_q;
    assign baud_write_data     = baud_dat_q;
    assign baud_write_location = baud_loc_q;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed bench for spart_bus_ctrl: bus accesses, TX drain, RX fill/overrun, divisor writes, reset abort.
module tb_spart_bus_ctrl;
    import spart_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          iocs;
    logic          iorw;
    logic [1:0]    ioaddr;
    wire  [DW-1:0] databus;
    logic          drv_en;
    logic [DW-1:0] drv_dat;
    logic          rda;
    logic [DW-1:0] recieve_read_line;
    logic          recieve_read_en;
    logic          tbr;
    logic [DW-1:0] write_line;
    logic          transmit_write_en;
    logic [DW-1:0] baud_write_data;
    logic          baud_write_en;
    logic          baud_write_location;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            rx_en_cnt = 0;
    logic [DW-1:0] tx_dat_q [$];
    int            tx_cyc_q [$];

    assign databus = drv_en ? drv_dat : {DW{1'bz}};

    always #5 clk = ~clk;

    spart_bus_ctrl #(.DATA_W(DW), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .iocs                (iocs),
        .iorw                (iorw),
        .ioaddr              (ioaddr),
        .databus             (databus),
        .rda                 (rda),
        .recieve_read_line   (recieve_read_line),
        .recieve_read_en     (recieve_read_en),
        .tbr                 (tbr),
        .write_line          (write_line),
        .transmit_write_en   (transmit_write_en),
        .baud_write_data     (baud_write_data),
        .baud_write_en       (baud_write_en),
        .baud_write_location (baud_write_location)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (transmit_write_en) begin
            tx_dat_q.push_back(write_line);
            tx_cyc_q.push_back(cyc);
        end
        if (recieve_read_en) rx_en_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [DW-1:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_en = 1'b1; drv_dat = d;
        tick();
        iocs = 1'b0; drv_en = 1'b0;
    endtask

    task automatic chk_read(input string tag, input logic [1:0] a, input logic [DW-1:0] exp);
        logic [DW-1:0] d;
        iocs = 1'b1; iorw = 1'b1; ioaddr = a; drv_en = 1'b0;
        @(negedge clk);
        d = databus;
        chk(tag, 32'(d), 32'(exp));
        tick();
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic rx_char(input logic [DW-1:0] c);
        rda = 1'b1; recieve_read_line = c;
        tick();
        tick();
        rda = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; drv_en = 1'b0; drv_dat = '0;
        rda = 1'b0; recieve_read_line = '0; tbr = 1'b0;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk("rst_txen", 32'(transmit_write_en), 0);
        chk("rst_wline", 32'(write_line), 0);
        chk("rst_rxen", 32'(recieve_read_en), 0);
        chk("rst_baud_en", 32'(baud_write_en), 0);
        chk("rst_baud_dat", 32'(baud_write_data), 0);
        chk("rst_baud_loc", 32'(baud_write_location), 0);
        iorw = 1'b1; ioaddr = ADDR_STATUS; drv_en = 1'b1; drv_dat = 8'h00;
        #1;
        chk("bus_released", 32'(databus), 0);
        tick();
        drv_en = 1'b0; iorw = 1'b0; rst = 1'b0;
        tick();
        chk_read("rst_status", ADDR_STATUS, 8'h02);

        // TX: three characters, 3-cycle spacing
        tbr = 1'b1;
        tx_dat_q.delete(); tx_cyc_q.delete();
        c0 = cyc;
        bus_write(ADDR_DATA, 8'h41);
        bus_write(ADDR_DATA, 8'h42);
        bus_write(ADDR_DATA, 8'h43);
        repeat (10) tick();
        chk("tx3_count", 32'(tx_dat_q.size()), 3);
        for (int i = 0; i < 3; i++) begin
            chk("tx3_data", 32'(tx_dat_q[i]), 32'h41 + 32'(i));
            chk("tx3_cycle", 32'(tx_cyc_q[i]), 32'(c0 + 2 + 3 * i));
        end

        // TX full: 8 writes held, 9th dropped
        tbr = 1'b0;
        tx_dat_q.delete(); tx_cyc_q.delete();
        for (int i = 0; i < 8; i++) bus_write(ADDR_DATA, 8'h50 + 8'(i));
        bus_write(ADDR_DATA, 8'h99);
        chk_read("txfull_status", ADDR_STATUS, 8'h00);
        chk("txfull_nosend", 32'(tx_dat_q.size()), 0);
        tbr = 1'b1;
        repeat (30) tick();
        chk("txfull_count", 32'(tx_dat_q.size()), 8);
        for (int i = 0; i < 8; i++) chk("txfull_data", 32'(tx_dat_q[i]), 32'h50 + 32'(i));
        chk_read("txdrained_status", ADDR_STATUS, 8'h02);

        // RX: latency, then fill past capacity
        rx_en_cnt = 0;
        rda = 1'b1; recieve_read_line = 8'h10;
        @(negedge clk);
        chk("rx_en_lat0", 32'(recieve_read_en), 0);
        tick();
        @(negedge clk);
        chk("rx_en_lat1", 32'(recieve_read_en), 1);
        tick();
        rda = 1'b0;
        chk_read("rx_avail_status", ADDR_STATUS, 8'h13);
        for (int i = 1; i < 9; i++) rx_char(8'h10 + 8'(i));
        chk("rx_take_count", 32'(rx_en_cnt), 9);
        chk_read("rx_ovr_status", ADDR_STATUS, 8'h87);
        chk_read("rx_ovr_cleared", ADDR_STATUS, 8'h83);
        for (int i = 0; i < 8; i++) chk_read("rx_data", ADDR_DATA, 8'h10 + 8'(i));
        chk_read("rx_empty_data", ADDR_DATA, 8'h00);
        chk_read("rx_empty_status", ADDR_STATUS, 8'h02);

        // Divisor writes
        iocs = 1'b1; iorw = 1'b0; ioaddr = ADDR_DB_LO; drv_en = 1'b1; drv_dat = 8'h2A;
        @(negedge clk);
        chk("baud_en_access", 32'(baud_write_en), 0);
        tick();
        ioaddr = ADDR_DB_HI; drv_dat = 8'h01;
        @(negedge clk);
        chk("baud_lo_en", 32'(baud_write_en), 1);
        chk("baud_lo_dat", 32'(baud_write_data), 32'h2A);
        chk("baud_lo_loc", 32'(baud_write_location), 0);
        tick();
        iocs = 1'b0; drv_en = 1'b0;
        @(negedge clk);
        chk("baud_hi_en", 32'(baud_write_en), 1);
        chk("baud_hi_dat", 32'(baud_write_data), 32'h01);
        chk("baud_hi_loc", 32'(baud_write_location), 1);
        tick();
        @(negedge clk);
        chk("baud_en_single", 32'(baud_write_en), 0);
        tick();
        chk_read("div_read", ADDR_DB_LO, 8'h00);

        // Simultaneous pop and push on a full RX FIFO
        for (int i = 0; i < 8; i++) rx_char(8'h60 + 8'(i));
        chk_read("simul_pre_status", ADDR_STATUS, 8'h83);
        rda = 1'b1; recieve_read_line = 8'h68;
        tick();
        iocs = 1'b1; iorw = 1'b1; ioaddr = ADDR_DATA;
        @(negedge clk);
        chk("simul_take", 32'(recieve_read_en), 1);
        chk("simul_head", 32'(databus), 32'h60);
        tick();
        iocs = 1'b0; iorw = 1'b0; rda = 1'b0;
        tick();
        chk_read("simul_status", ADDR_STATUS, 8'h83);
        for (int i = 0; i < 8; i++) chk_read("simul_data", ADDR_DATA, 8'h61 + 8'(i));

        // Reset during a TX pulse
        rx_char(8'h33);
        tbr = 1'b0;
        bus_write(ADDR_DATA, 8'h77);
        chk_read("rstmid_pre_status", ADDR_STATUS, 8'h13);
        tx_dat_q.delete(); tx_cyc_q.delete();
        tbr = 1'b1;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_pulse", 32'(transmit_write_en), 1);
        chk("rstmid_wline", 32'(write_line), 32'h77);
        tick();
        @(negedge clk);
        chk("rstmid_abort", 32'(transmit_write_en), 0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("rstmid_sends", 32'(tx_dat_q.size()), 1);
        chk_read("rstmid_status", ADDR_STATUS, 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
